// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage execute/write-back datapath with a private register
// file, ALU, HI/LO pair and a restoring iterative divider. One operation is
// accepted per cycle; its result is captured into the W stage on the accept
// edge and committed to the register file on the following edge, with the
// W stage forwarded into the next operation's operand read.
module datapath_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_COUNT   = 32,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8,
    parameter int V0_REG      = 2,
    localparam int AW         = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [4:0]            op,
    input  logic [AW-1:0]         rs,
    input  logic [AW-1:0]         rt,
    input  logic [AW-1:0]         rd,
    input  logic                  RegDst,
    input  logic                  ALUSrc,
    input  logic [15:0]           imm,
    input  logic [4:0]            shamt,
    input  logic                  RegWrite,
    input  logic                  B_link,
    input  logic [DATA_WIDTH-1:0] instr_address,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  N,
    output logic                  Z,
    output logic                  EQ,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] register_v0
);

    localparam int DW2 = 2 * DATA_WIDTH;
    localparam int CW  = $clog2(DATA_WIDTH);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_LUI   = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
    localparam logic [4:0] OP_MTHI  = 5'd17;
    localparam logic [4:0] OP_MTLO  = 5'd18;

    // Two's-complement magnitude; the most negative value maps to its
    // unsigned bit pattern, which is the correct magnitude.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? DATA_WIDTH'(-v) : DATA_WIDTH'(v);
    endfunction

    // Architectural state
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    // W stage
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [AW-1:0]         w_dst_q, w_dst_d;
    logic                  w_wen_q, w_wen_d;
    logic                  n_q, n_d, z_q, z_d, eq_q, eq_d;

    // Divider state
    logic                  busy_q, busy_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic                  q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;

    // E-stage combinational signals
    logic                         accept;
    logic [DATA_WIDTH-1:0]        rs_val, rt_val, op1, op2, imm_sx, imm_zx, result;
    logic [4:0]                   sh_amt;
    logic                         has_result;
    logic signed [DW2-1:0]        mul_s;
    logic [DW2-1:0]               mul_u;
    logic [DATA_WIDTH:0]          div_shift, div_trial;
    logic [DATA_WIDTH-1:0]        quo_step, rem_step;

    assign accept      = issue_valid && issue_ready;
    assign issue_ready = !busy_q;
    assign busy        = busy_q;
    assign alu_out     = w_data_q;
    assign N           = n_q;
    assign Z           = z_q;
    assign EQ          = eq_q;
    assign register_v0 = regs_q[V0_REG];

    // E stage: operand read with W-stage forwarding, ALU and write-back control
    always_comb begin
        rs_val = (w_wen_q && (w_dst_q == rs) && (rs != '0)) ? w_data_q : regs_q[rs];
        rt_val = (w_wen_q && (w_dst_q == rt) && (rt != '0)) ? w_data_q : regs_q[rt];
        if (rs == '0) rs_val = '0;
        if (rt == '0) rt_val = '0;

        imm_sx = DATA_WIDTH'($signed(imm));
        imm_zx = DATA_WIDTH'(imm);
        op1    = rs_val;
        if (ALUSrc)
            op2 = ((op == OP_AND) || (op == OP_OR) || (op == OP_XOR)) ? imm_zx : imm_sx;
        else
            op2 = rt_val;
        sh_amt = ALUSrc ? shamt : rs_val[4:0];

        mul_s = DW2'($signed(op1)) * DW2'($signed(op2));
        mul_u = DW2'(op1) * DW2'(op2);

        result     = '0;
        has_result = 1'b1;
        case (op)
            OP_ADD:  result = op1 + op2;
            OP_SUB:  result = op1 - op2;
            OP_AND:  result = op1 & op2;
            OP_OR:   result = op1 | op2;
            OP_XOR:  result = op1 ^ op2;
            OP_SLL:  result = rt_val << sh_amt;
            OP_SRL:  result = rt_val >> sh_amt;
            OP_SRA:  result = DATA_WIDTH'($signed(rt_val) >>> sh_amt);
            OP_SLT:  result = DATA_WIDTH'($signed(op1) < $signed(op2));
            OP_SLTU: result = DATA_WIDTH'(op1 < op2);
            OP_LUI:  result = DATA_WIDTH'({imm, 16'h0000});
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: has_result = 1'b0;
        endcase

        // Link writes replace both the data and the default destination.
        w_data_d = w_data_q;
        w_dst_d  = RegDst ? rd : rt;
        w_wen_d  = 1'b0;
        n_d      = n_q;
        z_d      = z_q;
        eq_d     = eq_q;
        if (accept && (has_result || B_link)) begin
            if (B_link) begin
                w_data_d = instr_address + DATA_WIDTH'(LINK_OFFSET);
                w_dst_d  = RegDst ? rd : AW'(LINK_REG);
            end else begin
                w_data_d = result;
            end
            w_wen_d = RegWrite && (w_dst_d != '0);
            n_d     = w_data_d[DATA_WIDTH-1];
            z_d     = (w_data_d == '0);
            eq_d    = (op1 == op2);
        end
    end

    // Register file commit from the W stage; register 0 is never written
    always_comb begin
        regs_d = regs_q;
        if (w_wen_q && (w_dst_q != '0))
            regs_d[w_dst_q] = w_data_q;
    end

    // Divider iteration and HI/LO updates from multiply, moves and divide completion
    always_comb begin
        div_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        div_trial = div_shift - {1'b0, dvs_q};
        quo_step  = {quo_q[DATA_WIDTH-2:0], !div_trial[DATA_WIDTH]};
        rem_step  = div_trial[DATA_WIDTH] ? div_shift[DATA_WIDTH-1:0] : div_trial[DATA_WIDTH-1:0];

        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        div0_d  = div0_q;

        if (busy_q) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                busy_d = 1'b0;
                if (div0_q) begin
                    lo_d = '1;
                    hi_d = dvd_q;
                end else begin
                    lo_d = q_neg_q ? DATA_WIDTH'(-quo_step) : quo_step;
                    hi_d = r_neg_q ? DATA_WIDTH'(-rem_step) : rem_step;
                end
            end
        end else if (accept) begin
            case (op)
                OP_MULT:  {hi_d, lo_d} = mul_s;
                OP_MULTU: {hi_d, lo_d} = mul_u;
                OP_MTHI:  hi_d = rs_val;
                OP_MTLO:  lo_d = rs_val;
                OP_DIV, OP_DIVU: begin
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = rs_val;
                    div0_d  = (rt_val == '0);
                    if (op == OP_DIV) begin
                        quo_d   = magnitude(rs_val);
                        dvs_d   = magnitude(rt_val);
                        q_neg_d = rs_val[DATA_WIDTH-1] ^ rt_val[DATA_WIDTH-1];
                        r_neg_d = rs_val[DATA_WIDTH-1];
                    end else begin
                        quo_d   = rs_val;
                        dvs_d   = rt_val;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset clears everything and aborts a divide in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            w_data_q <= '0;
            w_dst_q  <= '0;
            w_wen_q  <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            w_data_q <= w_data_d;
            w_dst_q  <= w_dst_d;
            w_wen_q  <= w_wen_d;
            n_q      <= n_d;
            z_q      <= z_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            dvd_q    <= dvd_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed testbench for datapath_pipe with hand-computed expected values.
module tb_datapath_pipe;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        RegDst, ALUSrc;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        RegWrite, B_link;
    logic [31:0] instr_address;
    logic [31:0] alu_out;
    logic        N, Z, EQ, busy;
    logic [31:0] register_v0;

    int checks = 0;
    int errors = 0;

    datapath_pipe dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .imm(imm), .shamt(shamt), .RegWrite(RegWrite), .B_link(B_link),
        .instr_address(instr_address), .alu_out(alu_out), .N(N), .Z(Z), .EQ(EQ),
        .busy(busy), .register_v0(register_v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for issue_ready, presents one op for one accept edge,
    // and returns #1 after that edge so the W stage is visible.
    task automatic issue(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic rdst, input logic asrc,
                         input logic [15:0] im, input logic [4:0] sh, input logic rw,
                         input logic bl, input logic [31:0] pc);
        int w = 0;
        while (!issue_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $error("FAIL issue_wait: observed timeout expected issue_ready");
        end
        op = o; rs = s; rt = t; rd = d; RegDst = rdst; ALUSrc = asrc;
        imm = im; shamt = sh; RegWrite = rw; B_link = bl; instr_address = pc;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    // rt = rs <op> imm
    task automatic op_i(input logic [4:0] o, input logic [4:0] t, input logic [4:0] s, input logic [15:0] im);
        issue(o, s, t, 5'd0, 1'b0, 1'b1, im, 5'd0, 1'b1, 1'b0, 32'h0);
    endtask

    // rd = rs <op> rt
    task automatic op_r(input logic [4:0] o, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        issue(o, s, t, d, 1'b1, 1'b0, 16'h0, 5'd0, 1'b1, 1'b0, 32'h0);
    endtask

    int  n;
    logic held_ok;

    initial begin
        reset = 1'b0; issue_valid = 1'b0; op = '0; rs = '0; rt = '0; rd = '0;
        RegDst = 1'b0; ALUSrc = 1'b0; imm = '0; shamt = '0; RegWrite = 1'b0;
        B_link = 1'b0; instr_address = '0;

        #12;
        check("rst_alu_out", alu_out, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ready", {31'h0, issue_ready}, 32'h1);
        check("rst_v0", register_v0, 32'h0);
        reset = 1'b1;

        // ADDI r2 = r0 + 5, visible in the regfile one edge after the W stage
        op_i(5'd0, 5'd2, 5'd0, 16'd5);
        check("addi_alu_out", alu_out, 32'd5);
        check("v0_not_yet", register_v0, 32'h0);
        @(posedge clk); #1;
        check("v0_written", register_v0, 32'd5);

        // Back-to-back dependency through the forwarding path
        op_i(5'd0, 5'd1, 5'd0, 16'd7);
        op_r(5'd0, 5'd3, 5'd1, 5'd1);
        check("fwd_add", alu_out, 32'd14);
        check("fwd_eq", {31'h0, EQ}, 32'h1);

        // Zero extension for logical immediates, LUI, SRA by shamt
        op_i(5'd3, 5'd1, 5'd0, 16'hFFFF);
        check("ori_zext", alu_out, 32'h0000FFFF);
        op_i(5'd10, 5'd4, 5'd0, 16'h8000);
        check("lui", alu_out, 32'h80000000);
        check("lui_n", {31'h0, N}, 32'h1);
        issue(5'd7, 5'd0, 5'd4, 5'd5, 1'b1, 1'b1, 16'h0, 5'd4, 1'b1, 1'b0, 32'h0);
        check("sra_shamt", alu_out, 32'hF8000000);
        op_i(5'd0, 5'd7, 5'd0, 16'hFFFF);
        check("addi_sext", alu_out, 32'hFFFFFFFF);
        op_i(5'd2, 5'd8, 5'd7, 16'h8000);
        check("andi_zext", alu_out, 32'h00008000);
        op_r(5'd8, 5'd9, 5'd7, 5'd1);
        check("slt", alu_out, 32'h1);
        op_r(5'd9, 5'd9, 5'd7, 5'd1);
        check("sltu", alu_out, 32'h0);

        // Multiply: signed, then unsigned with MFLO directly after
        op_i(5'd0, 5'd10, 5'd0, 16'd2);
        issue(5'd11, 5'd7, 5'd10, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        op_r(5'd15, 5'd11, 5'd0, 5'd0);
        check("mult_hi", alu_out, 32'hFFFFFFFF);
        op_r(5'd16, 5'd11, 5'd0, 5'd0);
        check("mult_lo", alu_out, 32'hFFFFFFFE);
        issue(5'd18, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        op_r(5'd16, 5'd11, 5'd0, 5'd0);
        check("mtlo_zero", alu_out, 32'h0);
        issue(5'd12, 5'd7, 5'd10, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        op_r(5'd16, 5'd11, 5'd0, 5'd0);
        check("multu_lo_next", alu_out, 32'hFFFFFFFE);
        op_r(5'd15, 5'd11, 5'd0, 5'd0);
        check("multu_hi", alu_out, 32'h1);

        // Signed divide -7 / 2
        op_i(5'd0, 5'd12, 5'd0, 16'hFFF9);
        issue(5'd13, 5'd12, 5'd10, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("div_busy", {31'h0, busy}, 32'h1);
        n = 0;
        while (!issue_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("div_stall_cycles", n, 32'd32);
        check("div_busy_done", {31'h0, busy}, 32'h0);
        op_r(5'd16, 5'd11, 5'd0, 5'd0);
        check("div_lo", alu_out, 32'hFFFFFFFD);
        op_r(5'd15, 5'd11, 5'd0, 5'd0);
        check("div_hi", alu_out, 32'hFFFFFFFF);

        // Unsigned divide by zero with an MFLO held valid during the divide
        op_i(5'd0, 5'd13, 5'd0, 16'd10);
        issue(5'd14, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        op = 5'd16; rs = 5'd0; rt = 5'd0; rd = 5'd11; RegDst = 1'b1; ALUSrc = 1'b0;
        RegWrite = 1'b1; B_link = 1'b0;
        issue_valid = 1'b1;
        n = 0;
        held_ok = 1'b1;
        while (!issue_ready && n < 100) begin
            if (alu_out !== 32'd10) held_ok = 1'b0;
            n++;
            @(posedge clk); #1;
        end
        check("divu_stall_cycles", n, 32'd32);
        check("held_not_accepted", {31'h0, held_ok}, 32'h1);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        check("divu0_lo", alu_out, 32'hFFFFFFFF);
        op_r(5'd15, 5'd11, 5'd0, 5'd0);
        check("divu0_hi", alu_out, 32'd10);

        // Link write to LINK_REG, read back through forwarding
        issue(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1, 1'b1, 32'h100);
        check("link_data", alu_out, 32'h108);
        op_r(5'd0, 5'd14, 5'd31, 5'd0);
        check("link_r31", alu_out, 32'h108);

        // Writes to r0 are discarded and never forwarded
        op_i(5'd0, 5'd0, 5'd0, 16'd5);
        op_r(5'd0, 5'd15, 5'd0, 5'd0);
        check("r0_zero", alu_out, 32'h0);
        check("r0_z_flag", {31'h0, Z}, 32'h1);

        // Reset in the middle of a divide
        issue(5'd14, 5'd13, 5'd10, 5'd0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("mid_div_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, issue_ready}, 32'h1);
        check("abort_alu_out", alu_out, 32'h0);
        check("abort_v0", register_v0, 32'h0);
        #1;
        reset = 1'b1;
        op_r(5'd15, 5'd11, 5'd0, 5'd0);
        check("abort_hi", alu_out, 32'h0);
        op_r(5'd16, 5'd11, 5'd0, 5'd0);
        check("abort_lo", alu_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
